// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/control slice.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Legal BRANCH_STAGE values
  localparam int unsigned BRANCH_EX  = 2;
  localparam int unsigned BRANCH_MEM = 3;

  // Shadow entries carry register numbers at this fixed width; narrower ports are zero-extended.
  localparam int unsigned REG_AW_MAX = 8;
  typedef logic [REG_AW_MAX-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t wr;
    logic regwrite;
    logic memread;
  } stage_t;

  function automatic logic stage_match(input stage_t s, input reg_t r);
    return s.valid & s.regwrite & (s.wr != '0) & (s.wr == r);
  endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface mips_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_wr;
  logic              id_regwrite;
  logic              id_memread;
  logic              branch_taken;
  logic              mem_ready;
  logic              pc_en;
  logic              ifid_en;
  logic              pipe_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr, id_regwrite, id_memread,
           branch_taken, mem_ready,
    input  pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr, id_regwrite, id_memread,
           branch_taken, mem_ready,
    output pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/mips_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_hazard_ctrl.sv
// Hazard/control unit for the 5-stage MIPS core: shadow scoreboard, forwarding,
// load-use interlock, branch flush, memory freeze and performance counters.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter int unsigned FWD_EN       = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  mips_hazard_ctrl_if.slave hz
);
  if ((BRANCH_STAGE != BRANCH_EX) && (BRANCH_STAGE != BRANCH_MEM)) begin : g_bad_stage
    $error("mips_hazard_ctrl: BRANCH_STAGE must be 2 or 3");
  end
  if (REG_AW > REG_AW_MAX) begin : g_bad_aw
    $error("mips_hazard_ctrl: REG_AW exceeds REG_AW_MAX");
  end

  typedef struct packed {
    stage_t st;
    reg_t   rs;
    reg_t   rt;
    logic   uses_rs;
    logic   uses_rt;
  } ex_t;

  function automatic reg_t ext(input logic [REG_AW-1:0] r);
    return reg_t'(r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input reg_t r,
                                         input stage_t mem, input stage_t wb);
    if (used && stage_match(mem, r))     return FWD_MEM;
    else if (used && stage_match(wb, r)) return FWD_WB;
    else                                 return FWD_RF;
  endfunction

  ex_t    ex_q, ex_d;
  stage_t mem_q, mem_d, wb_q, wb_d;
  logic   dep_ex, dep_mem, haz;
  logic   pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush;
  logic   stall_inc, flush_inc;
  logic   unused_wb_memread;

  // WB only needs to be matched, never load-checked
  assign unused_wb_memread = wb_q.memread;

  always_comb begin
    dep_ex  = (hz.id_uses_rs & stage_match(ex_q.st, ext(hz.id_rs))) |
              (hz.id_uses_rt & stage_match(ex_q.st, ext(hz.id_rt)));
    dep_mem = (hz.id_uses_rs & stage_match(mem_q, ext(hz.id_rs))) |
              (hz.id_uses_rt & stage_match(mem_q, ext(hz.id_rt)));
    if (FWD_EN != 0) haz = hz.id_valid & ex_q.st.memread & dep_ex;
    else             haz = hz.id_valid & (dep_ex | dep_mem);
  end

  always_comb begin
    {pc_en, ifid_en, pipe_en}                  = 3'b111;
    {ifid_flush, idex_flush, exmem_flush}      = 3'b000;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, pipe_en}             = 3'b000;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
    end else if (!hz.mem_ready) begin
      {pc_en, ifid_en, pipe_en} = 3'b000;
    end else if (hz.branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = (BRANCH_STAGE == BRANCH_MEM);
      flush_inc   = 1'b1;
    end else if (haz) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end
  end

  always_comb begin
    hz.fwd_a = FWD_RF;
    hz.fwd_b = FWD_RF;
    if ((FWD_EN != 0) && !rst) begin
      hz.fwd_a = fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
      hz.fwd_b = fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
    end
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = exmem_flush ? '0 : ex_q.st;
    ex_d  = '0;
    if (!idex_flush) begin
      ex_d.st.valid    = hz.id_valid;
      ex_d.st.wr       = ext(hz.id_wr);
      ex_d.st.regwrite = hz.id_regwrite;
      ex_d.st.memread  = hz.id_memread;
      ex_d.rs          = ext(hz.id_rs);
      ex_d.rt          = ext(hz.id_rt);
      ex_d.uses_rs     = hz.id_uses_rs;
      ex_d.uses_rt     = hz.id_uses_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (pipe_en) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.pipe_en     = pipe_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i(clk), .clr_i(rst), .en_i(stall_inc), .cnt_o(hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i(clk), .clr_i(rst), .en_i(flush_inc), .cnt_o(hz.flush_cnt)
  );
endmodule
